// File: rtl/shr_pkg.sv
// shr_pkg: shared types and helpers for the sequential right shifter.
//   state_t  - controller states (IDLE, SHIFT, DONE)
//   calc_cw  - width of the shift-amount field for a given word width
//   sat_amt  - clamps a requested shift count to the word width
package shr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Enough bits to encode every count from 0 up to and including width.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

  // Counts beyond the word width are pointless, so they saturate at width.
  function automatic int sat_amt(input int amt, input int width);
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/shr_seq_if.sv
// shr_seq_if: start/data/result bundle of the sequential right shifter.
//   start, din, amt, arith, sin : requester -> shifter
//   dout, sout, ready, done     : shifter -> requester
// The master modport is the requester side, the slave modport the shifter.
interface shr_seq_if
  import shr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = calc_cw(WIDTH)
);

  logic             start;
  logic [WIDTH-1:0] din;
  logic [CW-1:0]    amt;
  logic             arith;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             ready;
  logic             done;

  modport master (
    output start, din, amt, arith, sin,
    input  dout, sout, ready, done
  );

  modport slave (
    input  start, din, amt, arith, sin,
    output dout, sout, ready, done
  );

endinterface

// File: rtl/shr_step.sv
// shr_step: combinational single-bit right shift.
//   word    in  WIDTH  word to shift
//   fill    in  1      bit entering at the MSB
//   shifted out WIDTH  {fill, word[WIDTH-1:1]}
//   dropped out 1      word[0], the bit pushed out of the LSB
module shr_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted,
  output logic             dropped
);

  assign shifted = {fill, word[WIDTH-1:1]};
  assign dropped = word[0];

endmodule

// File: rtl/shr_seq.sv
// shr_seq: sequential multi-cycle right shifter / serial-to-parallel front end.
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset
//   bus  shr_seq_if.slave
//        start/din/amt/arith sampled on the accept edge (start while ready)
//        sin sampled on each shift edge, used as fill when arith is clear
//        dout  registered shift register contents
//        sout  registered LSB dropped by the latest shift
//        ready high only while idle
//        done  registered one-cycle completion pulse
module shr_seq
  import shr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  shr_seq_if.slave   bus
);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             arith_q;
  logic [WIDTH-1:0] dout_q;
  logic             sout_q;
  logic             done_q;

  logic [CW-1:0]    load_cnt;
  logic             fill;
  logic [WIDTH-1:0] shifted;
  logic             dropped;

  assign load_cnt = CW'(sat_amt(int'(bus.amt), WIDTH));

  // Arithmetic mode replicates the sign bit; otherwise the serial input
  // enters at the top, so the first bit consumed ends up lowest.
  assign fill = arith_q ? dout_q[WIDTH-1] : bus.sin;

  shr_step #(.WIDTH(WIDTH)) u_step (
    .word    (dout_q),
    .fill    (fill),
    .shifted (shifted),
    .dropped (dropped)
  );

  // done is raised on the edge that enters DONE, so it lines up with the
  // single DONE cycle. A load never touches sout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      arith_q <= 1'b0;
      dout_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dout_q  <= bus.din;
            cnt     <= load_cnt;
            arith_q <= bus.arith;
            if (load_cnt == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sout_q <= dropped;
          dout_q <= shifted;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout  = dout_q;
  assign bus.sout  = sout_q;
  assign bus.done  = done_q;
  assign bus.ready = (state == IDLE);

endmodule
